freelist_ckpt: RTL and testbench

- N-wide physical-register freelist for the R10K-style rename stage, with NUM_CKPT branch checkpoints for single-cycle misprediction recovery.
- Replaces the rebuild-from-architectural-map-table recovery path.
- Sits between Dispatch (allocate, take checkpoint), Retire (free old tags) and branch resolution (resolve or recover).

---
 rtl/freelist_ckpt_pkg.sv | 37 +++
 rtl/freelist_ckpt_psel.sv | 32 +++
 rtl/freelist_ckpt.sv | 162 ++++++++++++++++
 tb/tb_freelist_ckpt.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freelist_ckpt_pkg.sv
// Shared definitions for the checkpointed physical-register freelist.
// Holds the sizing constants, the tag / checkpoint-id typedefs and a
// population-count helper. This package has no ports.
package freelist_ckpt_pkg;

  localparam int N            = 3;
  localparam int PR_COUNT     = 64;
  localparam int ARCH_COUNT   = 32;
  localparam int NUM_CKPT     = 4;
  localparam bit EXCLUDE_ZERO = 1'b1;

  localparam int TAG_W  = $clog2(PR_COUNT);
  localparam int CNT_W  = $clog2(N + 1);
  localparam int FC_W   = $clog2(PR_COUNT + 1);
  localparam int CK_W   = $clog2(NUM_CKPT);
  localparam int LANE_W = $clog2(N);

  typedef logic [TAG_W-1:0]    phys_tag_t;
  typedef logic [CK_W-1:0]     ckpt_id_t;
  typedef logic [PR_COUNT-1:0] tag_mask_t;
  typedef logic [NUM_CKPT-1:0] ckpt_mask_t;
  typedef logic [FC_W-1:0]     free_cnt_t;

  // Architectural tags 0..ARCH_COUNT-1 start out mapped; the rest are free.
  localparam tag_mask_t RESET_FREE =
    ~((tag_mask_t'(1) << ARCH_COUNT) - tag_mask_t'(1));

  function automatic free_cnt_t popcount(input tag_mask_t m);
    free_cnt_t c;
    c = '0;
    for (int i = 0; i < PR_COUNT; i++) begin
      c = c + free_cnt_t'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/freelist_ckpt_psel.sv
// psel_n: lowest-index-first priority selector.
// Ports:
//   req   - request bitmap, WIDTH bits
//   idx   - indices of the lowest PICKS set bits, ascending (unused lanes 0)
//   count - how many lanes of idx are meaningful, min(PICKS, popcount(req))
module psel_n #(
  parameter int WIDTH = 64,
  parameter int PICKS = 3,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(PICKS + 1)
) (
  input  logic [WIDTH-1:0]            req,
  output logic [PICKS-1:0][IDX_W-1:0] idx,
  output logic [CNT_W-1:0]            count
);

  always_comb begin
    int found;
    idx   = '0;
    found = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && (found < PICKS)) begin
        for (int p = 0; p < PICKS; p++) begin
          if (p == found) idx[p] = IDX_W'(i);
        end
        found = found + 1;
      end
    end
    count = CNT_W'(found);
  end

endmodule

// File: rtl/freelist_ckpt.sv
// freelist_ckpt: N-wide physical-register freelist with NUM_CKPT branch
// checkpoints for single-cycle misprediction recovery.
// Ports:
//   clock, reset_n                  - clock, async active-low reset
//   alloc_cnt                       - tags taken by Dispatch (lanes 0..alloc_cnt-1)
//   free_tags/free_avail/free_count - offered tags, how many offered, total free
//   retire_en/retire_tag            - per-lane tag returns from Retire
//   ckpt_free_valid/ckpt_free_id    - lowest unused checkpoint slot
//   ckpt_take/ckpt_lane             - branch dispatched in lane ckpt_lane claims the slot
//   resolve_en/resolve_id           - branch predicted correctly, release slot
//   recover_en/recover_id           - misprediction, restore slot
module freelist_ckpt
  import freelist_ckpt_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [CNT_W-1:0]        alloc_cnt,
  output phys_tag_t [N-1:0]       free_tags,
  output logic [CNT_W-1:0]        free_avail,
  output free_cnt_t               free_count,
  input  logic [N-1:0]            retire_en,
  input  phys_tag_t [N-1:0]       retire_tag,
  output logic                    ckpt_free_valid,
  output ckpt_id_t                ckpt_free_id,
  input  logic                    ckpt_take,
  input  logic [LANE_W-1:0]       ckpt_lane,
  input  logic                    resolve_en,
  input  ckpt_id_t                resolve_id,
  input  logic                    recover_en,
  input  ckpt_id_t                recover_id
);

  tag_mask_t  free_q, free_d;
  free_cnt_t  free_count_q, free_count_d;
  ckpt_mask_t valid_q, valid_d;
  ckpt_mask_t older_q [NUM_CKPT];
  ckpt_mask_t older_d [NUM_CKPT];
  tag_mask_t  since_q [NUM_CKPT];
  tag_mask_t  since_d [NUM_CKPT];

  logic [CNT_W-1:0]        grant;
  logic                    take;
  tag_mask_t               alloc_mask, since_new, retire_mask, restored, live_since;
  ckpt_mask_t              kill, resolve_clr;
  logic                    retire_double, retire_live;
  logic [0:0][CK_W-1:0]    ckpt_pick;
  logic                    ckpt_pick_cnt;

  psel_n #(.WIDTH(PR_COUNT), .PICKS(N)) u_tag_sel (
    .req   (free_q),
    .idx   (free_tags),
    .count (free_avail)
  );

  psel_n #(.WIDTH(NUM_CKPT), .PICKS(1)) u_ckpt_sel (
    .req   (~valid_q),
    .idx   (ckpt_pick),
    .count (ckpt_pick_cnt)
  );

  assign ckpt_free_valid = ckpt_pick_cnt;
  assign ckpt_free_id    = ckpt_pick[0];
  assign free_count      = free_count_q;

  always_comb begin
    // A recovery squashes the whole dispatch group, so nothing is granted.
    grant = recover_en ? '0 : ((alloc_cnt > free_avail) ? free_avail : alloc_cnt);
    take  = ckpt_take && ckpt_free_valid && !recover_en;

    // Tags in lanes after the branch belong to the branch's shadow.
    alloc_mask = '0;
    since_new  = '0;
    for (int l = 0; l < N; l++) begin
      if (CNT_W'(l) < grant) begin
        alloc_mask[free_tags[l]] = 1'b1;
        if (LANE_W'(l) > ckpt_lane) since_new[free_tags[l]] = 1'b1;
      end
    end

    retire_mask   = '0;
    retire_double = 1'b0;
    for (int l = 0; l < N; l++) begin
      if (retire_en[l] && !(EXCLUDE_ZERO && (retire_tag[l] == '0))) begin
        retire_mask[retire_tag[l]] = 1'b1;
        if (free_q[retire_tag[l]]) retire_double = 1'b1;
      end
    end

    live_since = '0;
    for (int j = 0; j < NUM_CKPT; j++) begin
      if (valid_q[j]) live_since = live_since | since_q[j];
    end
    retire_live = |(retire_mask & live_since);

    // The recovered slot and every slot taken while it was live die together.
    kill     = '0;
    restored = '0;
    if (recover_en) begin
      restored         = since_q[recover_id];
      kill[recover_id] = 1'b1;
      for (int j = 0; j < NUM_CKPT; j++) begin
        if (valid_q[j] && older_q[j][recover_id]) kill[j] = 1'b1;
      end
    end

    resolve_clr = '0;
    if (resolve_en) resolve_clr[resolve_id] = 1'b1;

    free_d       = (free_q & ~alloc_mask) | retire_mask | restored;
    free_count_d = free_count_q + popcount(retire_mask) + popcount(restored)
                   - free_cnt_t'(grant);

    // Surviving older slots drop the restored tags so a later recovery of
    // them does not hand the same tags back a second time.
    for (int j = 0; j < NUM_CKPT; j++) begin
      valid_d[j] = valid_q[j];
      older_d[j] = older_q[j] & ~resolve_clr;
      since_d[j] = since_q[j];
      if (valid_q[j]) since_d[j] = (since_q[j] | alloc_mask) & ~restored;
      if (resolve_clr[j] || kill[j]) begin
        valid_d[j] = 1'b0;
        older_d[j] = '0;
        since_d[j] = '0;
      end
      if (take && (ckpt_free_id == CK_W'(j))) begin
        valid_d[j] = 1'b1;
        older_d[j] = valid_q & ~resolve_clr;
        since_d[j] = since_new;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      free_q       <= RESET_FREE;
      free_count_q <= free_cnt_t'(PR_COUNT - ARCH_COUNT);
      valid_q      <= '0;
      older_q      <= '{default: '0};
      since_q      <= '{default: '0};
    end else begin
      free_q       <= free_d;
      free_count_q <= free_count_d;
      valid_q      <= valid_d;
      older_q      <= older_d;
      since_q      <= since_d;
    end
  end

  a_alloc_legal: assert property (@(posedge clock) disable iff (!reset_n)
    !recover_en |-> (alloc_cnt <= free_avail));
  a_retire_not_free: assert property (@(posedge clock) disable iff (!reset_n)
    !retire_double);
  a_retire_not_live: assert property (@(posedge clock) disable iff (!reset_n)
    !retire_live);
  a_take_has_slot: assert property (@(posedge clock) disable iff (!reset_n)
    (ckpt_take && !recover_en) |-> ckpt_free_valid);
  a_resolve_recover_ids: assert property (@(posedge clock) disable iff (!reset_n)
    (resolve_en && recover_en) |-> (resolve_id != recover_id));
  a_count_matches: assert property (@(posedge clock) disable iff (!reset_n)
    free_count_q == popcount(free_q));

endmodule

// File: tb/tb_freelist_ckpt.sv
// Testbench for freelist_ckpt. Keeps a reference model built on a free-tag
// set plus an ordered allocation log: a checkpoint remembers its position in
// the log, and recovering it hands back every still-held tag logged after it.
module tb_freelist_ckpt;
  import freelist_ckpt_pkg::*;

  logic              clock;
  logic              reset_n;
  logic [CNT_W-1:0]  alloc_cnt;
  phys_tag_t [N-1:0] free_tags;
  logic [CNT_W-1:0]  free_avail;
  free_cnt_t         free_count;
  logic [N-1:0]      retire_en;
  phys_tag_t [N-1:0] retire_tag;
  logic              ckpt_free_valid;
  ckpt_id_t          ckpt_free_id;
  logic              ckpt_take;
  logic [LANE_W-1:0] ckpt_lane;
  logic              resolve_en;
  ckpt_id_t          resolve_id;
  logic              recover_en;
  ckpt_id_t          recover_id;

  freelist_ckpt dut (
    .clock(clock), .reset_n(reset_n), .alloc_cnt(alloc_cnt),
    .free_tags(free_tags), .free_avail(free_avail), .free_count(free_count),
    .retire_en(retire_en), .retire_tag(retire_tag),
    .ckpt_free_valid(ckpt_free_valid), .ckpt_free_id(ckpt_free_id),
    .ckpt_take(ckpt_take), .ckpt_lane(ckpt_lane),
    .resolve_en(resolve_en), .resolve_id(resolve_id),
    .recover_en(recover_en), .recover_id(recover_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int err_cnt = 0;
  int chk_cnt = 0;
  bit chk_en  = 0;

  typedef struct { int tag; int seq; } log_t;
  bit   m_free  [PR_COUNT];
  bit   m_valid [NUM_CKPT];
  int   m_order [NUM_CKPT];
  int   m_mark  [NUM_CKPT];
  log_t m_log[$];
  int   m_seq;
  int   m_order_ctr;

  function automatic int m_count();
    int c = 0;
    for (int t = 0; t < PR_COUNT; t++) if (m_free[t]) c++;
    return c;
  endfunction

  function automatic int m_avail();
    int c = m_count();
    return (c < N) ? c : N;
  endfunction

  function automatic int m_nth_free(input int n);
    int k = 0;
    for (int t = 0; t < PR_COUNT; t++) begin
      if (m_free[t]) begin
        if (k == n) return t;
        k++;
      end
    end
    return -1;
  endfunction

  function automatic int m_free_slot();
    for (int s = 0; s < NUM_CKPT; s++) if (!m_valid[s]) return s;
    return -1;
  endfunction

  task automatic m_reset();
    for (int t = 0; t < PR_COUNT; t++) m_free[t] = (t >= ARCH_COUNT);
    for (int s = 0; s < NUM_CKPT; s++) begin
      m_valid[s] = 0; m_order[s] = 0; m_mark[s] = 0;
    end
    m_log = {};
    m_seq = 0;
    m_order_ctr = 0;
  endtask

  task automatic expectEq(input string name, input int actual, input int expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput();
    int avail = m_avail();
    int slot  = m_free_slot();
    expectEq("free_count", int'(free_count), m_count());
    expectEq("free_avail", int'(free_avail), avail);
    for (int l = 0; l < avail; l++) expectEq("free_tags", int'(free_tags[l]), m_nth_free(l));
    expectEq("ckpt_free_valid", int'(ckpt_free_valid), (slot >= 0) ? 1 : 0);
    if (slot >= 0) expectEq("ckpt_free_id", int'(ckpt_free_id), slot);
  endtask

  always @(negedge clock) if (reset_n && chk_en) checkOutput();

  task automatic idleInputs();
    alloc_cnt = '0; retire_en = '0; retire_tag = '0; ckpt_take = 0;
    ckpt_lane = '0; resolve_en = 0; resolve_id = '0; recover_en = 0; recover_id = '0;
  endtask

  // One cycle of stimulus; rt* < 0 leaves that retire lane idle.
  task automatic applyStimulus(input int alloc, input int take, input int lane,
                               input int res, input int rid, input int rec, input int kid,
                               input int rt0, input int rt1, input int rt2);
    int rt[N];
    int gtag[N];
    int avail, grant, slot, mark, kord;
    bit take_ok;
    log_t keep[$];
    rt[0] = rt0; rt[1] = rt1; rt[2] = rt2;
    alloc_cnt  = CNT_W'(alloc);
    ckpt_take  = (take != 0);
    ckpt_lane  = LANE_W'(lane);
    resolve_en = (res != 0);
    resolve_id = CK_W'(rid);
    recover_en = (rec != 0);
    recover_id = CK_W'(kid);
    for (int l = 0; l < N; l++) begin
      retire_en[l]  = (rt[l] >= 0);
      retire_tag[l] = (rt[l] >= 0) ? TAG_W'(rt[l]) : '0;
    end
    avail = m_avail();
    grant = (rec != 0) ? 0 : ((alloc > avail) ? avail : alloc);
    for (int l = 0; l < N; l++) gtag[l] = (l < grant) ? m_nth_free(l) : -1;
    slot    = m_free_slot();
    take_ok = (take != 0) && (rec == 0) && (slot >= 0);

    @(posedge clock);
    if (rec != 0) begin
      kord = m_order[kid];
      keep = {};
      foreach (m_log[i]) begin
        if (m_log[i].seq >= m_mark[kid]) m_free[m_log[i].tag] = 1;
        else keep.push_back(m_log[i]);
      end
      m_log = keep;
      for (int s = 0; s < NUM_CKPT; s++)
        if (m_valid[s] && m_order[s] > kord) m_valid[s] = 0;
      m_valid[kid] = 0;
    end
    if (res != 0) m_valid[rid] = 0;
    mark = -1;
    for (int l = 0; l < grant; l++) begin
      if (take_ok && l == lane + 1) mark = m_seq;
      m_free[gtag[l]] = 0;
      m_log.push_back('{tag: gtag[l], seq: m_seq});
      m_seq++;
    end
    if (take_ok) begin
      if (mark < 0) mark = m_seq;
      m_valid[slot] = 1;
      m_order[slot] = m_order_ctr;
      m_order_ctr++;
      m_mark[slot]  = mark;
    end
    for (int l = 0; l < N; l++) begin
      if (rt[l] > 0) begin
        m_free[rt[l]] = 1;
        keep = {};
        foreach (m_log[i]) if (m_log[i].tag != rt[l]) keep.push_back(m_log[i]);
        m_log = keep;
      end
    end
    @(negedge clock);
    #1;
    idleInputs();
  endtask

  initial begin
    reset_n = 0;
    idleInputs();
    m_reset();
    repeat (2) @(negedge clock);
    #1 reset_n = 1;
    chk_en = 1;
    @(negedge clock);
    #1;
    $display("[TB] reset state");
    expectEq("rst free_count", int'(free_count), 32);
    expectEq("rst free_tags0", int'(free_tags[0]), 32);
    expectEq("rst free_tags1", int'(free_tags[1]), 33);
    expectEq("rst free_tags2", int'(free_tags[2]), 34);
    expectEq("rst free_avail", int'(free_avail), 3);
    expectEq("rst ckpt_free_id", int'(ckpt_free_id), 0);

    applyStimulus(3, 0, 0, 0, 0, 0, 0, -1, -1, -1);
    expectEq("alloc free_count", int'(free_count), 29);
    expectEq("alloc free_tags0", int'(free_tags[0]), 35);

    $display("[TB] checkpoint and recover");
    applyStimulus(3, 1, 0, 0, 0, 0, 0, -1, -1, -1);
    applyStimulus(3, 0, 0, 0, 0, 0, 0, -1, -1, -1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, -1, -1, -1);
    expectEq("rec free_count", int'(free_count), 28);
    expectEq("rec free_tags0", int'(free_tags[0]), 36);
    expectEq("rec free_tags2", int'(free_tags[2]), 38);
    expectEq("rec ckpt_free_id", int'(ckpt_free_id), 0);

    $display("[TB] nested checkpoints");
    applyStimulus(3, 1, 1, 0, 0, 0, 0, -1, -1, -1);
    applyStimulus(3, 1, 2, 0, 0, 0, 0, -1, -1, -1);
    expectEq("nest ckpt_free_id", int'(ckpt_free_id), 2);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, -1, -1, -1);
    expectEq("nest free_count", int'(free_count), 26);
    expectEq("nest free_tags0", int'(free_tags[0]), 38);
    expectEq("nest ckpt_free_id after", int'(ckpt_free_id), 0);

    $display("[TB] resolve");
    applyStimulus(2, 1, 0, 0, 0, 0, 0, -1, -1, -1);
    applyStimulus(3, 1, 0, 0, 0, 0, 0, -1, -1, -1);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, -1, -1, -1);
    expectEq("resolve ckpt_free_id", int'(ckpt_free_id), 0);
    expectEq("resolve free_count", int'(free_count), 20);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, -1, -1, -1);
    expectEq("resolve rec free_count", int'(free_count), 23);
    expectEq("resolve rec free_tags0", int'(free_tags[0]), 41);
    expectEq("resolve rec free_tags2", int'(free_tags[2]), 43);

    $display("[TB] drain and retire");
    for (int it = 0; it < 30 && m_count() > 0; it++)
      applyStimulus(m_avail(), 0, 0, 0, 0, 0, 0, -1, -1, -1);
    expectEq("drain free_count", int'(free_count), 0);
    expectEq("drain free_avail", int'(free_avail), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, -1, -1);
    expectEq("retire0 free_count", int'(free_count), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 33, -1, -1);
    expectEq("retire33 free_count", int'(free_count), 1);
    expectEq("retire33 free_tags0", int'(free_tags[0]), 33);

    $display("[TB] same-cycle conflict");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 20, 21, 22);
    applyStimulus(3, 1, 0, 0, 0, 0, 0, -1, -1, -1);
    expectEq("conf pre free_count", int'(free_count), 1);
    expectEq("conf pre ckpt_free_id", int'(ckpt_free_id), 1);
    applyStimulus(3, 1, 0, 0, 0, 1, 0, 50, -1, -1);
    expectEq("conf free_count", int'(free_count), 4);
    expectEq("conf free_tags0", int'(free_tags[0]), 21);
    expectEq("conf free_tags2", int'(free_tags[2]), 33);
    expectEq("conf ckpt_free_id", int'(ckpt_free_id), 0);

    $display("[TB] async reset");
    reset_n = 0;
    #1;
    expectEq("async free_count", int'(free_count), 32);
    expectEq("async free_tags0", int'(free_tags[0]), 32);
    expectEq("async ckpt_free_valid", int'(ckpt_free_valid), 1);
    m_reset();
    @(negedge clock);
    #1 reset_n = 1;
    applyStimulus(3, 0, 0, 0, 0, 0, 0, -1, -1, -1);
    expectEq("post-reset free_count", int'(free_count), 29);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
